fproc_arbiter: RTL

- Shares one function-processor (fproc) lookup resource between N_CORES proc instances.
- Each core issues an fproc request (id) when its ctrl asserts fproc enable, then stalls until ready.
- The arbiter queues requests one-deep per core, grants them round-robin, forwards the id to the shared resource and returns data plus a one-cycle ready pulse to the requesting core.

---
 rtl/fproc_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/fproc_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fproc_arb_pkg.sv
// Shared types and constants for the fproc arbiter: FSM state encoding and timeout fill value.
// No logic; imported by the arbiter top.
package fproc_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Replicated to DATA_WIDTH when a WAIT times out.
    localparam logic TIMEOUT_FILL_BIT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, wrapping mod N.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = '0;
        for (int i = 0; i < N; i++) begin
            w_j = IW'((int'(i_ptr) + i) % N);
            if (!o_vld && i_req[w_j]) begin
                o_vld      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc lookup resource among N_CORES cores: one-deep pending slot per core, RR grant.
// Latency: request pulse t -> fp_enable t+2 -> core_ready one cycle after fp_ready (min t+4).
// Backpressure: cores stall until core_ready; repeat pulses while pending are dropped. FPROC_ARB_TIMEOUT_EN adds a WAIT timeout.
module fproc_arbiter
    import fproc_arb_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FPROC_ID_WIDTH = 8,
    parameter int CORE_IDX_WIDTH = $clog2(N_CORES),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_CORES-1:0]             core_enable,
    input  logic [N_CORES*FPROC_ID_WIDTH-1:0] core_id,
    output logic [N_CORES-1:0]             core_ready,
    output logic [N_CORES*DATA_WIDTH-1:0]  core_data,
    output logic                           fp_enable,
    output logic [FPROC_ID_WIDTH-1:0]      fp_id,
    output logic [CORE_IDX_WIDTH-1:0]      fp_core,
    input  logic                           fp_ready,
    input  logic [DATA_WIDTH-1:0]          fp_data,
    output logic                           busy,
    output logic                           timeout_err
);

    state_t                      r_state;
    logic [N_CORES-1:0]          r_pending;
    logic [FPROC_ID_WIDTH-1:0]   r_id_q [N_CORES];
    logic [CORE_IDX_WIDTH-1:0]   r_grant;
    logic [CORE_IDX_WIDTH-1:0]   r_rr_ptr;
    logic [N_CORES-1:0]          r_core_ready;
    logic [DATA_WIDTH-1:0]       r_core_data [N_CORES];
    logic                        r_fp_enable;
    logic [FPROC_ID_WIDTH-1:0]   r_fp_id;
    logic [CORE_IDX_WIDTH-1:0]   r_fp_core;

    logic [N_CORES-1:0]          w_gnt;
    logic [CORE_IDX_WIDTH-1:0]   w_gnt_idx;
    logic                        w_gnt_vld;
    logic [N_CORES-1:0]          w_pend_set;
    logic [N_CORES-1:0]          w_pend_clr;

`ifdef FPROC_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]             r_wait_cnt;
    logic                        r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    rr_arbiter #(
        .N  (N_CORES),
        .IW (CORE_IDX_WIDTH)
    ) u_rr (
        .i_req (r_pending),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_vld (w_gnt_vld)
    );

    // A pulse from a core that is already pending is a protocol violation and is dropped.
    assign w_pend_set = core_enable & ~r_pending;
    assign w_pend_clr = (r_state == ST_IDLE) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_core_ready <= '0;
            r_fp_enable  <= 1'b0;
            r_fp_id      <= '0;
            r_fp_core    <= '0;
            for (int k = 0; k < N_CORES; k++) begin
                r_id_q[k]      <= '0;
                r_core_data[k] <= '0;
            end
`ifdef FPROC_ARB_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_pending <= (r_pending | w_pend_set) & ~w_pend_clr;
            for (int k = 0; k < N_CORES; k++) begin
                if (w_pend_set[k]) begin
                    r_id_q[k] <= core_id[k*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_grant     <= w_gnt_idx;
                        r_fp_enable <= 1'b1;
                        r_fp_id     <= r_id_q[w_gnt_idx];
                        r_fp_core   <= w_gnt_idx;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_fp_enable <= 1'b0;
`ifdef FPROC_ARB_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fp_ready) begin
                        r_core_data[r_grant]  <= fp_data;
                        r_core_ready[r_grant] <= 1'b1;
                        r_state               <= ST_RESP;
                    end
`ifdef FPROC_ARB_TIMEOUT_EN
                    else if (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_core_data[r_grant]  <= {DATA_WIDTH{TIMEOUT_FILL_BIT}};
                        r_core_ready[r_grant] <= 1'b1;
                        r_timeout_err         <= 1'b1;
                        r_state               <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_core_ready <= '0;
                    r_rr_ptr     <= (int'(r_grant) == N_CORES - 1) ? '0 : r_grant + 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CORES; g++) begin : g_data
            assign core_data[g*DATA_WIDTH +: DATA_WIDTH] = r_core_data[g];
        end
    endgenerate

    assign core_ready = r_core_ready;
    assign fp_enable  = r_fp_enable;
    assign fp_id      = r_fp_id;
    assign fp_core    = r_fp_core;
    assign busy       = (r_state != ST_IDLE) || (|r_pending);

endmodule
